// File: rtl/cpu_mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM encoding, default width,
// and the iteration counter sizing helper.
package cpu_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    localparam int MULT_WIDTH = 32;

    function automatic int mult_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/seq_mult_unit.sv
// Radix-2 shift-add multiplier answering MULT/MULTU; {hi,lo} = a*b, one partial product per cycle.
// Latency WIDTH cycles from the accepting edge to done (fewer with SEQ_MULT_EARLY_OUT_EN defined).
// No backpressure: start is honoured in IDLE or DONE only; the CPU stalls on busy.
module seq_mult_unit
    import cpu_mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = mult_cnt_w(WIDTH);
    localparam int PW    = 2 * WIDTH;

    mult_state_e        state_q;
    logic [PW-1:0]      acc_q;
    logic [PW-1:0]      mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               neg_in;
    logic               accept;
    logic [PW-1:0]      acc_d;
    logic [PW-1:0]      mcand_d;
    logic [WIDTH-1:0]   mplier_d;
    logic [PW-1:0]      prod_d;
    logic               last_iter;

    // The most negative operand negates to itself, which is already its correct unsigned magnitude.
    always_comb begin
        a_mag  = (signed_op && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
        b_mag  = (signed_op && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
        neg_in = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
        accept = start && ((state_q == IDLE) || (state_q == DONE));
    end

    always_comb begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        prod_d   = neg_q ? (PW'(0) - acc_d) : acc_d;
    end

`ifdef SEQ_MULT_EARLY_OUT_EN
    // Once no multiplier bits remain the accumulator cannot change, so stop early.
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_d == '0);
`else
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (accept) begin
            state_q  <= RUN;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            cnt_q    <= '0;
            neg_q    <= neg_in;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_iter) begin
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        {hi_q, lo_q} <= prod_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed and randomized checks of seq_mult_unit against a plain-arithmetic product/latency model.
module tb_seq_mult_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          Reset;
    logic          start;
    logic          signed_op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_acc = 0;

    seq_mult_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx;
        longint sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    // Cycles from the accepting edge to done.
    function automatic int ref_lat(input logic [31:0] y, input logic s);
`ifdef SEQ_MULT_EARLY_OUT_EN
        logic [31:0] m;
        m = (s && y[31]) ? 32'(32'd0 - y) : y;
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) return i + 1;
        end
        return 1;
`else
        if (s && y === 32'hx) return 0;
        return 32;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic s);
        start     = 1'b1;
        a         = ia;
        b         = ib;
        signed_op = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_acc = cyc;
        a     = $urandom;
        b     = $urandom;
        signed_op = $urandom_range(0, 1);
    endtask

    task automatic wait_done(input string tag, output int lat);
        bit ok;
        ok  = 1'b1;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = cyc - n_acc;
                break;
            end
            if (!busy) ok = 1'b0;
        end
        chk($sformatf("%s_busy_held", tag), 64'(ok), 64'd1);
    endtask

    task automatic run_check(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                             input logic s, input logic [63:0] exp);
        int lat;
        issue(ia, ib, s);
        wait_done(tag, lat);
        chk($sformatf("%s_lat", tag), 64'(lat), 64'(ref_lat(ib, s)));
        chk($sformatf("%s_prod", tag), {hi, lo}, exp);
        chk($sformatf("%s_busy_at_done", tag), 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk($sformatf("%s_done_drop", tag), 64'(done), 64'd0);
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat;
        int pe;
        int extra_done;
        bit idle_ok;
        logic [31:0] rx;
        logic [31:0] ry;
        logic        rs;

        vecs[0] = '{32'd3,          32'd5,          1'b0, 64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'hFFFF_FFFE,  32'd3,          1'b1, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[3] = '{32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000};
        vecs[4] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'h0000_0000_0000_0001};
        vecs[5] = '{32'd12345,      32'd0,          1'b0, 64'h0};
        vecs[6] = '{32'd1,          32'h0000_0010,  1'b0, 64'h10};
        vecs[7] = '{32'd5,          32'd5,          1'b1, 64'd25};
        vecs[8] = '{32'd7,          32'hFFFF_FFF0,  1'b1, 64'hFFFF_FFFF_FFFF_FF90};

        Reset = 1'b1; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        Reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            chk($sformatf("model_v%0d", i), ref_prod(vecs[i].x, vecs[i].y, vecs[i].s), vecs[i].p);
            run_check($sformatf("dir%0d", i), vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].p);
        end

        // start during RUN must be ignored
`ifdef SEQ_MULT_EARLY_OUT_EN
        pe = 2;
`else
        pe = 10;
`endif
        issue(32'd7, 32'd9, 1'b0);
        repeat (pe - 1) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1; a = 32'd2; b = 32'd2; signed_op = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ign", lat);
        chk("ign_lat", 64'(lat), 64'(ref_lat(32'd9, 1'b0)));
        chk("ign_prod", {hi, lo}, 64'h3F);
        extra_done = 0;
        idle_ok = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
            if (busy) idle_ok = 1'b0;
        end
        chk("ign_no_second_done", 64'(extra_done), 64'd0);
        chk("ign_stays_idle", 64'(idle_ok), 64'd1);

        // back-to-back issue in the DONE cycle
        issue(32'd7, 32'd9, 1'b0);
        wait_done("b2b1", lat);
        chk("b2b1_prod", {hi, lo}, 64'h3F);
        start = 1'b1; a = 32'd4; b = 32'd4; signed_op = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_acc = cyc;
        chk("b2b_busy_rise", 64'(busy), 64'd1);
        chk("b2b_done_fall", 64'(done), 64'd0);
        chk("b2b_hold_prev", {hi, lo}, 64'h3F);
        @(posedge clk);
        #1;
        chk("b2b_hold_prev2", {hi, lo}, 64'h3F);
        wait_done("b2b2", lat);
        chk("b2b2_lat", 64'(lat), 64'(ref_lat(32'd4, 1'b0)));
        chk("b2b2_prod", {hi, lo}, 64'h10);
        @(posedge clk);
        #1;

        // synchronous reset part-way through
        issue(32'd6, 32'd6, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        Reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rmid_busy", 64'(busy), 64'd0);
        chk("rmid_done", 64'(done), 64'd0);
        chk("rmid_hilo", {hi, lo}, 64'd0);
        Reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rmid_busy2", 64'(busy), 64'd0);
        chk("rmid_hilo2", {hi, lo}, 64'd0);
        run_check("rmid_again", 32'd6, 32'd6, 1'b0, 64'h24);

        for (int i = 0; i < 30; i++) begin
            rx = $urandom;
            ry = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 300));
            if ($urandom_range(0, 3) == 0) ry = 32'd0 - ry;
            rs = $urandom_range(0, 1);
            run_check($sformatf("rnd%0d", i), rx, ry, rs, ref_prod(rx, ry, rs));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
